thread_sequencer: RTL and testbench
===================================

THREAD_SEQUENCER -- requirements
Module: thread_sequencer

Interface
REQ-001 Parameter NUM_INST, default 4, number of valid code entries in a loaded thread (1..255).
REQ-002 Parameter MAX_STEPS, default 255, execution-step budget before forced stop (1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to load thread_init and run it; sampled only in IDLE.
REQ-006 thread_init  input  my_pkg::thread_type  initial thread (data registers plus code).
REQ-007 join_thread_in  output  my_pkg::thread_type  current thread state driven to the downstream join/execute stage.
REQ-008 join_instruction  output  8  current instruction index driven to the join stage.
REQ-009 join_thread_out  input  my_pkg::thread_type  thread state after the join stage executes join_instruction (combinational return).
REQ-010 join_instruction_post  input  8  next instruction index returned by the join stage.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse marking completion.
REQ-013 timeout  output  1  valid with done; high when the run stopped on MAX_STEPS.
REQ-014 steps  output  8  number of instructions executed in the current/last run.
REQ-015 thread_result  output  my_pkg::thread_type  final thread state, held stable from done until next accepted start.

Function
REQ-016 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE & start=1: next edge captures thread_init into the thread register, join_instruction<=0, steps<=0, timeout<=0, state<=RUN.
REQ-018 IDLE & start=0: all registers hold.
REQ-019 RUN, each edge: thread register<=join_thread_out, join_instruction<=join_instruction_post, steps<=steps+1 (one instruction per cycle, no stall).
REQ-020 RUN -> DONE on the edge where join_instruction_post >= NUM_INST (end of program); thread_result<=join_thread_out on that same edge.
REQ-021 RUN -> DONE with timeout<=1 on the edge where steps+1 == MAX_STEPS and REQ-020 does not apply; thread_result<=join_thread_out.
REQ-022 End-of-program takes priority over timeout when both occur on the same edge (timeout=0).
REQ-023 RUN entered with index already >= NUM_INST (impossible after start, since index 0) is not a case to handle beyond REQ-020.
REQ-024 DONE lasts exactly one cycle with done=1; next edge -> IDLE unconditionally.
REQ-025 start asserted in RUN or DONE is ignored (not queued); start in the IDLE cycle immediately after DONE is accepted.
REQ-026 steps saturates at MAX_STEPS; no wrap.
REQ-027 busy=1 iff state==RUN; done=1 iff state==DONE; both combinational from state.
REQ-028 join_thread_in always equals the thread register; join_instruction always equals the index register.
REQ-029 Latency: start sampled at edge E0 -> a program of N sequential instructions (N<=NUM_INST, post=index+1) runs E1..EN, done high in cycle after EN.

Reset
REQ-030 rst=1 at an edge forces IDLE, thread register, thread_result to all-zero, join_instruction=0, steps=0, timeout=0, busy=0, done=0.
REQ-031 rst overrides start and any RUN/DONE activity, including mid-run; no done pulse is produced for an aborted run.

Verification
REQ-032 Load data0=35, data1=6, code MUL(0,1->2), SUB(2,1->3), ADD(0,1->0), DIV(2,0->1), NUM_INST=4, pulse start -> busy 4 cycles, done 1 cycle after 4th edge, steps=4, timeout=0, thread_result data0=41, data1=5, data2=210, data3=204.
REQ-033 Same program, MAX_STEPS=2 -> done after 2 RUN edges, timeout=1, steps=2, data2=210, data3=204, data0=35.
REQ-034 Join stage returning post=index (self-loop), MAX_STEPS=255 -> done after 255 steps, timeout=1, steps=255.
REQ-035 start held high through RUN and DONE -> second run begins only from IDLE cycle following done; second thread_init captured then.
REQ-036 rst asserted on 2nd RUN cycle -> next cycle IDLE, all outputs zero, no done pulse; subsequent start runs program to REQ-032 results.

Source files
------------

// File: rtl/thread_sequencer.sv
// Thread sequencer: loads a thread, steps it through an external join/execute
// stage one instruction per cycle, and stops at end of program or on the step budget.

package my_pkg;
    localparam int NUM_REGS = 4;
    localparam int CODE_LEN = 4;

    // Instruction byte layout: [7:6] opcode, [5:4] src1, [3:2] src2, [1:0] dst
    typedef struct packed {
        logic [NUM_REGS-1:0][15:0] data;
        logic [CODE_LEN-1:0][7:0]  code;
    } thread_type;
endpackage

module thread_sequencer #(
    parameter int NUM_INST  = 4,
    parameter int MAX_STEPS = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  my_pkg::thread_type thread_init,
    output my_pkg::thread_type join_thread_in,
    output logic [7:0]        join_instruction,
    input  my_pkg::thread_type join_thread_out,
    input  logic [7:0]        join_instruction_post,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [7:0]        steps,
    output my_pkg::thread_type thread_result
);

    localparam logic [7:0] C_NUM_INST  = 8'(NUM_INST);
    localparam logic [7:0] C_MAX_STEPS = 8'(MAX_STEPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    my_pkg::thread_type r_thread;
    my_pkg::thread_type r_result;
    logic [7:0]         r_index;
    logic [7:0]         r_steps;
    logic               r_timeout;

    logic [7:0]         w_stepsInc;
    logic               w_endOfProgram;
    logic               w_budgetSpent;

    // End of program wins over budget exhaustion when both land on the same edge
    assign w_stepsInc     = r_steps + 8'd1;
    assign w_endOfProgram = (join_instruction_post >= C_NUM_INST);
    assign w_budgetSpent  = (w_stepsInc == C_MAX_STEPS);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; start is only looked at while idle
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                if (w_endOfProgram || w_budgetSpent) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Thread, index, step count and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_thread  <= '0;
            r_result  <= '0;
            r_index   <= '0;
            r_steps   <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_thread  <= thread_init;
                        r_index   <= '0;
                        r_steps   <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_thread <= join_thread_out;
                    r_index  <= join_instruction_post;
                    if (r_steps < C_MAX_STEPS) begin
                        r_steps <= w_stepsInc;
                    end
                    if (w_endOfProgram) begin
                        r_result  <= join_thread_out;
                        r_timeout <= 1'b0;
                    end else if (w_budgetSpent) begin
                        r_result  <= join_thread_out;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy             = (r_state == S_RUN);
    assign done             = (r_state == S_DONE);
    assign timeout          = r_timeout;
    assign steps            = r_steps;
    assign join_thread_in   = r_thread;
    assign join_instruction = r_index;
    assign thread_result    = r_result;

endmodule

// File: tb/tb_thread_sequencer.sv
// Directed bench for thread_sequencer: a behavioural join stage executes
// ADD/SUB/MUL/DIV instructions, expected results are hand-computed constants.

module tb_thread_sequencer;
    import my_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       startShort;
    logic       selfLoop;
    thread_type threadInit;

    thread_type joinIn, joinOut, result;
    logic [7:0] joinIdx, joinPost, steps;
    logic       busy, done, timeout;

    thread_type joinInS, joinOutS, resultS;
    logic [7:0] joinIdxS, joinPostS, stepsS;
    logic       busyS, doneS, timeoutS;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Builds a thread holding the reference program with the given data registers
    function automatic thread_type mkThread(input logic [15:0] d0, input logic [15:0] d1,
                                            input logic [15:0] d2, input logic [15:0] d3);
        thread_type t;
        t.data[0] = d0;
        t.data[1] = d1;
        t.data[2] = d2;
        t.data[3] = d3;
        t.code[0] = {2'd2, 2'd0, 2'd1, 2'd2};
        t.code[1] = {2'd1, 2'd2, 2'd1, 2'd3};
        t.code[2] = {2'd0, 2'd0, 2'd1, 2'd0};
        t.code[3] = {2'd3, 2'd2, 2'd0, 2'd1};
        return t;
    endfunction

    // Behavioural join/execute stage: opcode 0 ADD, 1 SUB, 2 MUL, 3 DIV
    function automatic thread_type execInst(input thread_type t, input logic [7:0] idx);
        thread_type r;
        logic [7:0]  ins;
        logic [15:0] a, b, y;
        r = t;
        if (idx < 8'd4) begin
            ins = t.code[idx[1:0]];
            a = t.data[ins[5:4]];
            b = t.data[ins[3:2]];
            case (ins[7:6])
                2'd0:    y = a + b;
                2'd1:    y = a - b;
                2'd2:    y = a * b;
                default: y = (b == 16'd0) ? 16'd0 : a / b;
            endcase
            r.data[ins[1:0]] = y;
        end
        return r;
    endfunction

    assign joinOut   = selfLoop ? joinIn  : execInst(joinIn, joinIdx);
    assign joinPost  = selfLoop ? joinIdx : joinIdx + 8'd1;
    assign joinOutS  = execInst(joinInS, joinIdxS);
    assign joinPostS = joinIdxS + 8'd1;

    thread_sequencer #(.NUM_INST(4), .MAX_STEPS(255)) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .thread_init          (threadInit),
        .join_thread_in       (joinIn),
        .join_instruction     (joinIdx),
        .join_thread_out      (joinOut),
        .join_instruction_post(joinPost),
        .busy                 (busy),
        .done                 (done),
        .timeout              (timeout),
        .steps                (steps),
        .thread_result        (result)
    );

    thread_sequencer #(.NUM_INST(4), .MAX_STEPS(2)) u_dutShort (
        .clk                  (clk),
        .rst                  (rst),
        .start                (startShort),
        .thread_init          (threadInit),
        .join_thread_in       (joinInS),
        .join_instruction     (joinIdxS),
        .join_thread_out      (joinOutS),
        .join_instruction_post(joinPostS),
        .busy                 (busyS),
        .done                 (doneS),
        .timeout              (timeoutS),
        .steps                (stepsS),
        .thread_result        (resultS)
    );

    // Pulses start on the main instance and counts busy cycles until busy drops
    task automatic runMain(output int busyCycles);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        busyCycles = 0;
        while (busy === 1'b1 && busyCycles < 400) begin
            busyCycles++;
            @(negedge clk);
        end
    endtask

    task automatic runShort(output int busyCycles);
        @(negedge clk) startShort = 1'b1;
        @(negedge clk) startShort = 1'b0;
        busyCycles = 0;
        while (busyS === 1'b1 && busyCycles < 400) begin
            busyCycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags: busy=%b done=%b want 0 0", busy, done); end
        total++; if (steps !== 8'd0 || joinIdx !== 8'd0 || timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_counters: steps=%0d idx=%0d timeout=%b want 0 0 0", steps, joinIdx, timeout); end
        total++; if (joinIn !== '0 || result !== '0) begin bad++; $display("[TB] FAIL reset_thread: in=%h result=%h want 0", joinIn, result); end
        total++; if (doneS !== 1'b0 || busyS !== 1'b0) begin bad++; $display("[TB] FAIL reset_short: busy=%b done=%b want 0 0", busyS, doneS); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || steps !== 8'd0) begin bad++; $display("[TB] FAIL idle_hold: busy=%b steps=%0d want 0 0", busy, steps); end
    endtask

    task automatic test_program();
        int n;
        thread_type exp;
        threadInit = mkThread(16'd35, 16'd6, 16'd0, 16'd0);
        exp = mkThread(16'd41, 16'd5, 16'd210, 16'd204);
        runMain(n);
        total++; if (n !== 4) begin bad++; $display("[TB] FAIL prog_busy_cycles: got %0d want 4", n); end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL prog_done: got %b want 1", done); end
        total++; if (steps !== 8'd4) begin bad++; $display("[TB] FAIL prog_steps: got %0d want 4", steps); end
        total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL prog_timeout: got %b want 0", timeout); end
        total++; if (result !== exp) begin bad++; $display("[TB] FAIL prog_result: got %h want %h", result, exp); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL prog_done_pulse: done=%b busy=%b want 0 0", done, busy); end
        total++; if (result !== exp) begin bad++; $display("[TB] FAIL prog_result_hold: got %h want %h", result, exp); end
    endtask

    task automatic test_timeout();
        int n;
        thread_type exp;
        threadInit = mkThread(16'd35, 16'd6, 16'd0, 16'd0);
        exp = mkThread(16'd35, 16'd6, 16'd210, 16'd204);
        runShort(n);
        total++; if (n !== 2) begin bad++; $display("[TB] FAIL tmo_busy_cycles: got %0d want 2", n); end
        total++; if (doneS !== 1'b1 || timeoutS !== 1'b1) begin bad++; $display("[TB] FAIL tmo_flags: done=%b timeout=%b want 1 1", doneS, timeoutS); end
        total++; if (stepsS !== 8'd2) begin bad++; $display("[TB] FAIL tmo_steps: got %0d want 2", stepsS); end
        total++; if (resultS !== exp) begin bad++; $display("[TB] FAIL tmo_result: got %h want %h", resultS, exp); end
    endtask

    task automatic test_self_loop();
        int n;
        thread_type exp;
        selfLoop = 1'b1;
        exp = mkThread(16'd7, 16'd9, 16'd0, 16'd0);
        threadInit = exp;
        runMain(n);
        total++; if (n !== 255) begin bad++; $display("[TB] FAIL loop_busy_cycles: got %0d want 255", n); end
        total++; if (done !== 1'b1 || timeout !== 1'b1) begin bad++; $display("[TB] FAIL loop_flags: done=%b timeout=%b want 1 1", done, timeout); end
        total++; if (steps !== 8'd255) begin bad++; $display("[TB] FAIL loop_steps: got %0d want 255", steps); end
        total++; if (result !== exp) begin bad++; $display("[TB] FAIL loop_result: got %h want %h", result, exp); end
        @(negedge clk);
        selfLoop = 1'b0;
    endtask

    task automatic test_start_held();
        int n;
        thread_type expA, expB, initB;
        expA  = mkThread(16'd41, 16'd5, 16'd210, 16'd204);
        initB = mkThread(16'd10, 16'd3, 16'd0, 16'd0);
        expB  = mkThread(16'd13, 16'd2, 16'd30, 16'd27);
        threadInit = mkThread(16'd35, 16'd6, 16'd0, 16'd0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) threadInit = initB;
        n = 0;
        while (busy === 1'b1 && n < 400) begin n++; @(negedge clk); end
        total++; if (n !== 4 || done !== 1'b1) begin bad++; $display("[TB] FAIL held_first_run: cycles=%0d done=%b want 4 1", n, done); end
        total++; if (result !== expA) begin bad++; $display("[TB] FAIL held_first_result: got %h want %h", result, expA); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL held_idle_gap: busy=%b done=%b want 0 0", busy, done); end
        @(negedge clk);
        total++; if (busy !== 1'b1 || joinIn !== initB || joinIdx !== 8'd0) begin bad++; $display("[TB] FAIL held_second_capture: busy=%b idx=%0d in=%h want 1 0 %h", busy, joinIdx, joinIn, initB); end
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin n++; @(negedge clk); end
        total++; if (n !== 4 || done !== 1'b1) begin bad++; $display("[TB] FAIL held_second_run: cycles=%0d done=%b want 4 1", n, done); end
        total++; if (result !== expB) begin bad++; $display("[TB] FAIL held_second_result: got %h want %h", result, expB); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit sawDone;
        thread_type exp;
        exp = mkThread(16'd41, 16'd5, 16'd210, 16'd204);
        threadInit = mkThread(16'd35, 16'd6, 16'd0, 16'd0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin bad++; $display("[TB] FAIL abort_flags: busy=%b done=%b timeout=%b want 0 0 0", busy, done, timeout); end
        total++; if (steps !== 8'd0 || joinIdx !== 8'd0) begin bad++; $display("[TB] FAIL abort_counters: steps=%0d idx=%0d want 0 0", steps, joinIdx); end
        total++; if (joinIn !== '0 || result !== '0) begin bad++; $display("[TB] FAIL abort_thread: in=%h result=%h want 0", joinIn, result); end
        rst = 1'b0;
        sawDone = 1'b0;
        repeat (4) begin @(negedge clk); if (done !== 1'b0) sawDone = 1'b1; end
        total++; if (sawDone !== 1'b0) begin bad++; $display("[TB] FAIL abort_no_done: saw done=%b want 0", sawDone); end
        runMain(n);
        total++; if (n !== 4 || done !== 1'b1 || steps !== 8'd4) begin bad++; $display("[TB] FAIL abort_rerun: cycles=%0d done=%b steps=%0d want 4 1 4", n, done, steps); end
        total++; if (result !== exp) begin bad++; $display("[TB] FAIL abort_rerun_result: got %h want %h", result, exp); end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        startShort = 1'b0;
        selfLoop   = 1'b0;
        threadInit = '0;
        test_reset();
        test_program();
        test_timeout();
        test_self_loop();
        test_start_held();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
